// File: rtl/regfile_wr_arbiter_if.sv
// Bundle for the shared register-file write port: requester-side handshake
// plus the registered write-port outputs and arbiter status.
interface regfile_wr_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [ADDR_W-1:0]         rf_write_addr;
  logic [DATA_W-1:0]         rf_write_data;
  logic                      rf_write_en;
  logic [2:0]                grant_id;
  logic                      locked;

  modport master (
    output req_valid, req_lock, req_addr, req_data,
    input  req_ready, rf_write_addr, rf_write_data, rf_write_en, grant_id, locked
  );

  modport slave (
    input  req_valid, req_lock, req_addr, req_data,
    output req_ready, rf_write_addr, rf_write_data, rf_write_en, grant_id, locked
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter with burst lock in front of the register-file write port;
// the winning beat is registered and written one cycle after acceptance.
module regfile_wr_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 8,
  parameter int IDLE_TO   = 4
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  regfile_wr_arbiter_if.slave bus
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            r_state, w_nextState;
  logic [2:0]        r_rrPtr, w_nextRrPtr;
  logic [2:0]        r_owner, w_nextOwner;
  logic [7:0]        r_beatCnt, w_nextBeatCnt;
  logic [7:0]        r_idleCnt, w_nextIdleCnt;
  logic [2:0]        r_grantId;
  logic              r_wrEn;
  logic [ADDR_W-1:0] r_wrAddr;
  logic [DATA_W-1:0] r_wrData;

  logic [7:0]        w_validPad, w_lockPad, w_readyPad;
  logic [3:0]        w_scan;
  logic [2:0]        w_winIdx;
  logic              w_accept;
  logic              w_winLock;
  logic [ADDR_W-1:0] w_winAddr;
  logic [DATA_W-1:0] w_winData;

  function automatic logic [2:0] nextIdx(input logic [2:0] idx);
    return (idx == 3'(NUM_REQ - 1)) ? 3'd0 : idx + 3'd1;
  endfunction

  // Vectors are padded to 8 entries so a 3-bit index is always in range.
  always_comb begin
    w_validPad = '0;
    w_lockPad  = '0;
    w_validPad[NUM_REQ-1:0] = bus.req_valid;
    w_lockPad[NUM_REQ-1:0]  = bus.req_lock;
    w_readyPad = '0;
    w_winIdx   = r_owner;
    w_accept   = 1'b0;
    w_scan     = '0;
    if (i_rst_n) begin
      if (r_state == IDLE) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          w_scan = {1'b0, r_rrPtr} + 4'(k);
          if (w_scan >= 4'(NUM_REQ)) w_scan = w_scan - 4'(NUM_REQ);
          if (!w_accept && w_validPad[w_scan[2:0]]) begin
            w_accept = 1'b1;
            w_winIdx = w_scan[2:0];
          end
        end
      end else if (w_validPad[r_owner]) begin
        w_accept = 1'b1;
      end
      if (w_accept) w_readyPad[w_winIdx] = 1'b1;
    end
  end

  assign bus.req_ready = w_readyPad[NUM_REQ-1:0];
  assign w_winLock     = w_lockPad[w_winIdx];

  always_comb begin
    w_winAddr = '0;
    w_winData = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winIdx == 3'(i)) begin
        w_winAddr = bus.req_addr[i*ADDR_W +: ADDR_W];
        w_winData = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Lock release hands the round-robin pointer to the requester after the owner.
  always_comb begin
    w_nextState   = r_state;
    w_nextRrPtr   = r_rrPtr;
    w_nextOwner   = r_owner;
    w_nextBeatCnt = r_beatCnt;
    w_nextIdleCnt = r_idleCnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_winLock && (MAX_BURST > 1)) begin
            w_nextState   = LOCKED;
            w_nextOwner   = w_winIdx;
            w_nextBeatCnt = 8'd1;
            w_nextIdleCnt = 8'd0;
          end else begin
            w_nextRrPtr = nextIdx(w_winIdx);
          end
        end
      end
      LOCKED: begin
        if (w_accept) begin
          w_nextBeatCnt = r_beatCnt + 8'd1;
          w_nextIdleCnt = 8'd0;
          if (!w_winLock || (({1'b0, r_beatCnt} + 9'd1) >= 9'(MAX_BURST))) begin
            w_nextState   = IDLE;
            w_nextRrPtr   = nextIdx(r_owner);
            w_nextBeatCnt = 8'd0;
          end
        end else begin
          w_nextIdleCnt = r_idleCnt + 8'd1;
          if (({1'b0, r_idleCnt} + 9'd1) >= 9'(IDLE_TO)) begin
            w_nextState   = IDLE;
            w_nextRrPtr   = nextIdx(r_owner);
            w_nextBeatCnt = 8'd0;
            w_nextIdleCnt = 8'd0;
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_rrPtr   <= '0;
      r_owner   <= '0;
      r_beatCnt <= '0;
      r_idleCnt <= '0;
    end else begin
      r_state   <= w_nextState;
      r_rrPtr   <= w_nextRrPtr;
      r_owner   <= w_nextOwner;
      r_beatCnt <= w_nextBeatCnt;
      r_idleCnt <= w_nextIdleCnt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wrEn    <= 1'b0;
      r_wrAddr  <= '0;
      r_wrData  <= '0;
      r_grantId <= '0;
    end else begin
      r_wrEn <= w_accept;
      if (w_accept) begin
        r_wrAddr  <= w_winAddr;
        r_wrData  <= w_winData;
        r_grantId <= w_winIdx;
      end
    end
  end

  assign bus.rf_write_en   = r_wrEn;
  assign bus.rf_write_addr = r_wrAddr;
  assign bus.rf_write_data = r_wrData;
  assign bus.grant_id      = r_grantId;
  assign bus.locked        = (r_state == LOCKED);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: reset, round-robin, burst lock,
// idle timeout, lock drop, duplicate addresses and reset during a lock.
module tb_regfile_wr_arbiter;

  logic clk;
  logic rst_n;
  int   checkCount;
  int   errorCount;

  regfile_wr_arbiter_if #(.NUM_REQ(3), .ADDR_W(5), .DATA_W(16)) bus ();

  regfile_wr_arbiter #(
    .NUM_REQ(3), .ADDR_W(5), .DATA_W(16), .MAX_BURST(8), .IDLE_TO(4)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] valid, input logic [2:0] lock,
                               input logic [4:0] a0, input logic [4:0] a1,
                               input logic [4:0] a2, input logic [15:0] d0,
                               input logic [15:0] d1, input logic [15:0] d2);
    bus.req_valid = valid;
    bus.req_lock  = lock;
    bus.req_addr  = {a2, a1, a0};
    bus.req_data  = {d2, d1, d0};
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int g;
    checkCount = 0;
    errorCount = 0;

    // Reset held with everyone requesting
    rst_n = 1'b0;
    applyStimulus(3'b111, 3'b000, 5'd0, 5'd1, 5'd2, 16'hA000, 16'hA001, 16'hA002);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("rst_ready", 32'(bus.req_ready), 32'h0);
      checkOutput("rst_wen", 32'(bus.rf_write_en), 32'h0);
      checkOutput("rst_locked", 32'(bus.locked), 32'h0);
      checkOutput("rst_grant", 32'(bus.grant_id), 32'h0);
    end
    rst_n = 1'b1;
    #1;
    checkOutput("rst_first_ready", 32'(bus.req_ready), 32'h1);

    // Round-robin with all requesters valid
    for (int k = 0; k < 6; k++) begin
      g = k % 3;
      checkOutput("rr_ready", 32'(bus.req_ready), 32'(1 << g));
      tick();
      checkOutput("rr_wen", 32'(bus.rf_write_en), 32'h1);
      checkOutput("rr_data", 32'(bus.rf_write_data), 32'hA000 + 32'(g));
      checkOutput("rr_grant", 32'(bus.grant_id), 32'(g));
    end

    // Burst lock by requester 1, forced release after 8 beats
    applyStimulus(3'b010, 3'b010, 5'd0, 5'd1, 5'd2, 16'hA000, 16'hB000, 16'hA002);
    checkOutput("lk_ready0", 32'(bus.req_ready), 32'h2);
    tick();
    checkOutput("lk_locked0", 32'(bus.locked), 32'h1);
    checkOutput("lk_data0", 32'(bus.rf_write_data), 32'hB000);
    for (int n = 1; n < 8; n++) begin
      applyStimulus(3'b111, 3'b010, 5'd0, 5'd1, 5'd2, 16'hA000, 16'hB000 + 16'(n), 16'hA002);
      checkOutput("lk_ready", 32'(bus.req_ready), 32'h2);
      tick();
      checkOutput("lk_grant", 32'(bus.grant_id), 32'h1);
      checkOutput("lk_data", 32'(bus.rf_write_data), 32'hB000 + 32'(n));
      checkOutput("lk_locked", 32'(bus.locked), (n < 7) ? 32'h1 : 32'h0);
    end
    checkOutput("lk_after_ready", 32'(bus.req_ready), 32'h4);
    tick();
    checkOutput("lk_after_grant", 32'(bus.grant_id), 32'h2);
    checkOutput("lk_after_data", 32'(bus.rf_write_data), 32'hA002);

    // Idle timeout: requester 2 locks two beats then goes quiet
    applyStimulus(3'b100, 3'b100, 5'd0, 5'd1, 5'd2, 16'hA000, 16'hA001, 16'hD000);
    checkOutput("to_ready0", 32'(bus.req_ready), 32'h4);
    tick();
    checkOutput("to_locked0", 32'(bus.locked), 32'h1);
    applyStimulus(3'b100, 3'b100, 5'd0, 5'd1, 5'd2, 16'hA000, 16'hA001, 16'hD001);
    tick();
    checkOutput("to_data1", 32'(bus.rf_write_data), 32'hD001);
    applyStimulus(3'b001, 3'b000, 5'd0, 5'd1, 5'd2, 16'hE000, 16'hA001, 16'hD001);
    for (int c = 0; c < 4; c++) begin
      checkOutput("to_stall_ready", 32'(bus.req_ready), 32'h0);
      tick();
      checkOutput("to_stall_wen", 32'(bus.rf_write_en), 32'h0);
      checkOutput("to_locked", 32'(bus.locked), (c < 3) ? 32'h1 : 32'h0);
    end
    checkOutput("to_ready_r0", 32'(bus.req_ready), 32'h1);
    tick();
    checkOutput("to_grant_r0", 32'(bus.grant_id), 32'h0);
    checkOutput("to_data_r0", 32'(bus.rf_write_data), 32'hE000);

    // Lock dropped on the third beat of requester 0
    applyStimulus(3'b001, 3'b001, 5'd3, 5'd1, 5'd2, 16'hF003, 16'hA001, 16'hA002);
    tick();
    checkOutput("ld_addr3", 32'(bus.rf_write_addr), 32'd3);
    checkOutput("ld_locked3", 32'(bus.locked), 32'h1);
    applyStimulus(3'b001, 3'b001, 5'd4, 5'd1, 5'd2, 16'hF004, 16'hA001, 16'hA002);
    tick();
    checkOutput("ld_addr4", 32'(bus.rf_write_addr), 32'd4);
    checkOutput("ld_locked4", 32'(bus.locked), 32'h1);
    applyStimulus(3'b001, 3'b000, 5'd5, 5'd1, 5'd2, 16'hF005, 16'hA001, 16'hA002);
    tick();
    checkOutput("ld_addr5", 32'(bus.rf_write_addr), 32'd5);
    checkOutput("ld_data5", 32'(bus.rf_write_data), 32'hF005);
    checkOutput("ld_locked5", 32'(bus.locked), 32'h0);

    // Duplicate address: rr pointer is at 1, so requester 1 writes first
    applyStimulus(3'b011, 3'b000, 5'd7, 5'd7, 5'd2, 16'hC000, 16'hC001, 16'hA002);
    checkOutput("dup_ready1", 32'(bus.req_ready), 32'h2);
    tick();
    checkOutput("dup_addr1", 32'(bus.rf_write_addr), 32'd7);
    checkOutput("dup_data1", 32'(bus.rf_write_data), 32'hC001);
    applyStimulus(3'b001, 3'b000, 5'd7, 5'd7, 5'd2, 16'hC000, 16'hC001, 16'hA002);
    checkOutput("dup_ready0", 32'(bus.req_ready), 32'h1);
    tick();
    checkOutput("dup_addr0", 32'(bus.rf_write_addr), 32'd7);
    checkOutput("dup_data0", 32'(bus.rf_write_data), 32'hC000);

    // Reset in the middle of a requester 1 burst
    applyStimulus(3'b010, 3'b010, 5'd0, 5'd9, 5'd2, 16'hA000, 16'h9001, 16'hA002);
    tick();
    checkOutput("rml_locked", 32'(bus.locked), 32'h1);
    applyStimulus(3'b010, 3'b010, 5'd0, 5'd9, 5'd2, 16'hA000, 16'h9002, 16'hA002);
    tick();
    checkOutput("rml_data", 32'(bus.rf_write_data), 32'h9002);
    rst_n = 1'b0;
    #1;
    checkOutput("rml_ready_low", 32'(bus.req_ready), 32'h0);
    tick();
    checkOutput("rml_locked_rst", 32'(bus.locked), 32'h0);
    checkOutput("rml_wen_rst", 32'(bus.rf_write_en), 32'h0);
    checkOutput("rml_data_rst", 32'(bus.rf_write_data), 32'h0);
    rst_n = 1'b1;
    applyStimulus(3'b111, 3'b000, 5'd0, 5'd1, 5'd2, 16'hA000, 16'hA001, 16'hA002);
    checkOutput("rml_restart_ready", 32'(bus.req_ready), 32'h1);
    tick();
    checkOutput("rml_restart_grant", 32'(bus.grant_id), 32'h0);
    checkOutput("rml_restart_wen", 32'(bus.rf_write_en), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the register file's single write port (5-bit write_addr, 16-bit write_data, write_en) among NUM_REQ requesters, e.g. ALU writeback, load unit and host config.
- Uses round-robin arbitration with an optional burst lock, so one requester can perform back-to-back writes.
- The winning beat is registered and driven onto the register-file write port one cycle after acceptance.
- Sits directly in front of the register file in the receiver datapath.

Parameters:
NUM_REQ, 3, number of write requesters (2..8)
ADDR_W, 5, register address width (32 registers)
DATA_W, 16, register data width
MAX_BURST, 8, maximum accepted beats per lock tenure before forced release (1..255)
IDLE_TO, 4, consecutive cycles with owner req_valid low before lock release (1..255)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  synchronous reset, active-low
req_valid  in  NUM_REQ  per-requester write request
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_lock  in  NUM_REQ  per-requester lock request, sampled on an accepted beat
req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
req_data  in  NUM_REQ*DATA_W  packed data; requester i at [i*DATA_W +: DATA_W]
rf_write_addr  out  ADDR_W  to register file write_addr
rf_write_data  out  DATA_W  to register file write_data
rf_write_en  out  1  to register file write_en; active high
grant_id  out  3  index of the last accepted requester (registered)
locked  out  1  high while in the LOCKED state

Behaviour:
- Reset (rst_n low at a rising edge):
  - rf_write_en=0, rf_write_addr=0, rf_write_data=0, grant_id=0, locked=0.
  - State=IDLE, rr_ptr=0, beat_cnt=0, idle_cnt=0.
  - req_ready is all-zero while rst_n is low.
  - Reset mid-lock or mid-beat aborts everything; a beat whose output register has not yet been loaded is lost.
- Handshake:
  - A beat is accepted when req_valid[i] && req_ready[i] at a rising edge.
  - A requester holds valid/addr/data/lock stable until accepted.
  - req_ready is combinational from the state registers and req_valid only; it never depends on req_data.
- Output stage:
  - On accept: rf_write_addr/rf_write_data load the winner's addr/data, rf_write_en=1 for exactly that next cycle, grant_id=i.
  - No accept: rf_write_en=0 and addr/data hold their last values.
  - Latency from accept edge to write_en high is 1 cycle.
  - One write per cycle; full throughput with back-to-back accepts.
- State IDLE (round-robin):
  - Scan from rr_ptr upward, mod NUM_REQ; req_ready goes to the first i with req_valid[i].
  - On accept with req_lock[i]=0: rr_ptr=(i+1) mod NUM_REQ; stay in IDLE.
  - On accept with req_lock[i]=1: go to LOCKED with owner=i, beat_cnt=1, idle_cnt=0.
  - If MAX_BURST=1, the lock is released immediately (same as an unlocked grant).
- State LOCKED:
  - Only owner can receive req_ready; all other requesters stall.
  - Each owner accept: beat_cnt++, idle_cnt=0.
  - Each cycle with owner req_valid=0: idle_cnt++.
  - Release to IDLE with rr_ptr=(owner+1) mod NUM_REQ when any of these holds:
    - an accepted beat has req_lock=0 (that beat is still written);
    - beat_cnt reaches MAX_BURST on an accepted beat;
    - idle_cnt reaches IDLE_TO.
  - When released, the owner's next beat arbitrates normally in IDLE.
- Boundary conditions:
  - All requesters valid: grant order is rr_ptr, rr_ptr+1, ..., wrapping at NUM_REQ-1→0.
  - A lone requester is granted every cycle.
  - Duplicate addresses from different requesters are written in grant order; last write wins.
  - Counters are sized to hold 255 and never wrap.
  - A write to any address (0..31) is legal; this block does no address filtering.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with all req_valid=1 -> req_ready=000, rf_write_en=0, locked=0. Release -> first grant goes to requester 0.
- Round-robin: all three valid continuously, lock=0, data 0xA000+i -> grants 0,1,2,0,1,2. rf_write_en is high every cycle from cycle 2; rf_write_data follows 0xA000, 0xA001, 0xA002, ...
- Lock burst: requester 1 locks with 10 beats queued, MAX_BURST=8, others valid -> 8 consecutive grants to 1 (locked=1), then a forced release and the next grant goes to 2.
- Idle timeout: requester 2 locks, writes 2 beats, then drops valid; requester 0 valid -> requester 0 stalls for IDLE_TO=4 cycles, locked falls, requester 0 is granted the following cycle.
- Lock drop: requester 0 beats with lock=1,1,0 to addrs 3,4,5 -> three writes appear at addrs 3,4,5; after the third, locked=0 and rr_ptr=1.
- Reset mid-lock: rst_n=0 during a requester 1 burst -> next edge locked=0 and rf_write_en=0; after release, arbitration restarts at requester 0.
